// File: rtl/enemy_wave_scheduler.sv
`timescale 1ns/1ps
// enemy_wave_scheduler: enemy slot deployment FSM, shared game-tick
// strobes and frontmost live enemy tracking.
module enemy_wave_scheduler #(
  parameter int NSLOT       = 4,
  parameter int TICK_DIV    = 16,
  parameter int SPAWN_GAP   = 8,
  parameter int WAVE_LEN    = 6,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NSLOT-1:0]   slot_alive,
  input  logic [9*NSLOT-1:0] slot_pos,
  output logic [NSLOT-1:0]   spawn_req,
  output logic [1:0]         spawn_type,
  output logic               moveSCEN,
  output logic               damageSCEN,
  output logic [8:0]         enemy_front,
  output logic [3:0]         wave_num,
  output logic               wave_done,
  output logic               spawn_err
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int GW = $clog2(2*SPAWN_GAP+1);
  localparam int AW = $clog2(ACK_TIMEOUT+1);
  localparam int CW = $clog2(WAVE_LEN+1);
  localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  typedef enum logic [2:0] {
    IDLE, SPAWN_WAIT, SPAWN, ACK_WAIT, WAVE_CLEAR, INTERMISSION
  } state_e;

  state_e           state_q;
  logic [TW-1:0]    tick_q;
  logic [GW-1:0]    gap_q;
  logic [AW-1:0]    ack_q;
  logic [CW-1:0]    spawned_q;
  logic [SW-1:0]    sel_q;
  logic [NSLOT-1:0] req_q;
  logic [1:0]       type_q;
  logic             move_q;
  logic             damage_q;
  logic [8:0]       front_q;
  logic [3:0]       wave_q;
  logic             wd_q;
  logic             err_q;

  logic             tick_d;
  logic             free_d;
  logic [SW-1:0]    free_idx_d;
  logic [8:0]       front_d;
  logic [7:0]       tsum_d;
  logic [1:0]       type_d;

  always_comb begin
    tick_d     = enable && (tick_q == TW'(TICK_DIV-1));
    free_d     = 1'b0;
    free_idx_d = '0;
    // scan downward so the lowest free index wins
    for (int i = NSLOT-1; i >= 0; i--) begin
      if (!slot_alive[i]) begin
        free_d     = 1'b1;
        free_idx_d = SW'(i);
      end
    end
    front_d = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (slot_alive[i] && slot_pos[9*i +: 9] > front_d)
        front_d = slot_pos[9*i +: 9];
    end
    tsum_d = 8'(spawned_q) + 8'(wave_q);
    type_d = 2'(tsum_d % 8'd3) + 2'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      gap_q     <= '0;
      ack_q     <= '0;
      spawned_q <= '0;
      sel_q     <= '0;
      req_q     <= '0;
      type_q    <= '0;
      move_q    <= 1'b0;
      damage_q  <= 1'b0;
      front_q   <= '0;
      wave_q    <= '0;
      wd_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      req_q    <= '0;
      wd_q     <= 1'b0;
      move_q   <= tick_d && (state_q != IDLE);
      damage_q <= enable && move_q;
      front_q  <= front_d;
      if (enable) begin
        tick_q <= tick_d ? '0 : tick_q + 1'b1;
        case (state_q)
          IDLE: begin
            gap_q   <= '0;
            state_q <= SPAWN_WAIT;
          end
          SPAWN_WAIT: begin
            if (tick_d) begin
              if (gap_q == GW'(SPAWN_GAP-1)) begin
                gap_q   <= '0;
                state_q <= SPAWN;
              end else begin
                gap_q <= gap_q + 1'b1;
              end
            end
          end
          SPAWN: begin
            if (free_d) begin
              req_q   <= NSLOT'(1) << free_idx_d;
              type_q  <= type_d;
              sel_q   <= free_idx_d;
              ack_q   <= '0;
              state_q <= ACK_WAIT;
            end
          end
          ACK_WAIT: begin
            if (slot_alive[sel_q] || ack_q == AW'(ACK_TIMEOUT-1)) begin
              if (!slot_alive[sel_q])
                err_q <= 1'b1;
              spawned_q <= spawned_q + 1'b1;
              state_q   <= (spawned_q == CW'(WAVE_LEN-1)) ?
                           WAVE_CLEAR : SPAWN_WAIT;
            end else begin
              ack_q <= ack_q + 1'b1;
            end
          end
          WAVE_CLEAR: begin
            if (slot_alive == '0) begin
              wd_q      <= 1'b1;
              if (wave_q != 4'd15)
                wave_q <= wave_q + 1'b1;
              spawned_q <= '0;
              gap_q     <= '0;
              state_q   <= INTERMISSION;
            end
          end
          INTERMISSION: begin
            if (tick_d) begin
              if (gap_q == GW'(2*SPAWN_GAP-1)) begin
                gap_q   <= '0;
                state_q <= SPAWN_WAIT;
              end else begin
                gap_q <= gap_q + 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign spawn_req   = req_q;
  assign spawn_type  = type_q;
  assign moveSCEN    = move_q;
  assign damageSCEN  = damage_q;
  assign enemy_front = front_q;
  assign wave_num    = wave_q;
  assign wave_done   = wd_q;
  assign spawn_err   = err_q;
endmodule

// File: tb/tb_enemy_wave_scheduler.sv
`timescale 1ns/1ps
// Bench for enemy_wave_scheduler: directed wave walk-through followed
// by randomized play, both compared against a behavioural model.
module tb_enemy_wave_scheduler;
  localparam int NSLOT       = 4;
  localparam int TICK_DIV    = 16;
  localparam int SPAWN_GAP   = 8;
  localparam int WAVE_LEN    = 6;
  localparam int ACK_TIMEOUT = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               enable;
  logic [NSLOT-1:0]   slot_alive;
  logic [9*NSLOT-1:0] slot_pos;
  logic [NSLOT-1:0]   spawn_req;
  logic [1:0]         spawn_type;
  logic               moveSCEN;
  logic               damageSCEN;
  logic [8:0]         enemy_front;
  logic [3:0]         wave_num;
  logic               wave_done;
  logic               spawn_err;

  enemy_wave_scheduler #(
    .NSLOT(NSLOT), .TICK_DIV(TICK_DIV), .SPAWN_GAP(SPAWN_GAP),
    .WAVE_LEN(WAVE_LEN), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .slot_alive(slot_alive), .slot_pos(slot_pos),
    .spawn_req(spawn_req), .spawn_type(spawn_type),
    .moveSCEN(moveSCEN), .damageSCEN(damageSCEN),
    .enemy_front(enemy_front), .wave_num(wave_num),
    .wave_done(wave_done), .spawn_err(spawn_err)
  );

  always #5 clk = ~clk;

  // behavioural model: expected values of the outputs after each edge
  int               ecnt;
  bit               m_idle;
  bit               s_en;
  logic [NSLOT-1:0] s_alive;
  bit               exp_move, exp_damage, exp_wd, exp_err;
  logic [NSLOT-1:0] exp_req;
  int               exp_type, exp_wave, exp_front, spawned;

  task automatic mstep(output bit tk);
    int f;
    @(posedge clk);
    s_en    = enable;
    s_alive = slot_alive;
    tk = s_en && (ecnt == TICK_DIV-1);
    if (s_en) ecnt = (ecnt + 1) % TICK_DIV;
    exp_damage = s_en && exp_move;
    exp_move   = tk && !m_idle;
    exp_req    = '0;
    exp_wd     = 1'b0;
    f = 0;
    for (int i = 0; i < NSLOT; i++)
      if (s_alive[i] && int'(slot_pos[9*i +: 9]) > f)
        f = int'(slot_pos[9*i +: 9]);
    exp_front = f;
  endtask

  task automatic wait_ticks(input int n);
    int c;
    bit tk;
    c = 0;
    while (c < n) begin
      mstep(tk);
      if (tk) c++;
    end
  endtask

  initial begin : model
    bit tk;
    int sel, n;
    ecnt = 0; m_idle = 1; spawned = 0; exp_wave = 0; exp_err = 0;
    exp_move = 0; exp_damage = 0; exp_req = '0; exp_wd = 0;
    exp_type = 0; exp_front = 0;
    @(posedge reset);
    do mstep(tk); while (!s_en);
    m_idle = 0;
    forever begin
      wait_ticks(SPAWN_GAP);
      do mstep(tk); while (!(s_en && s_alive != '1));
      sel = 0;
      while (s_alive[sel]) sel++;
      exp_req  = NSLOT'(1) << sel;
      exp_type = 1 + (spawned + exp_wave) % 3;
      n = 0;
      forever begin
        mstep(tk);
        if (s_en) begin
          if (s_alive[sel]) break;
          n++;
          if (n == ACK_TIMEOUT) begin
            exp_err = 1;
            break;
          end
        end
      end
      spawned++;
      if (spawned == WAVE_LEN) begin
        do mstep(tk); while (!(s_en && s_alive == '0));
        exp_wd = 1;
        if (exp_wave < 15) exp_wave++;
        spawned = 0;
        wait_ticks(2*SPAWN_GAP);
      end
    end
  end

  // stimulus, unit responder and comparison
  int n_vec, n_err, cyc_n;
  bit chk_en, rand_mode;
  int resp_delay;
  int ack_due [NSLOT];

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc_n, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"}, spawn_req, 0);
    check({tag, "_type"}, spawn_type, 0);
    check({tag, "_move"}, moveSCEN, 0);
    check({tag, "_damage"}, damageSCEN, 0);
    check({tag, "_front"}, enemy_front, 0);
    check({tag, "_wave"}, wave_num, 0);
    check({tag, "_wdone"}, wave_done, 0);
    check({tag, "_err"}, spawn_err, 0);
  endtask

  task automatic nstep();
    int d, k;
    @(negedge clk);
    cyc_n++;
    if (chk_en) begin
      check("moveSCEN", moveSCEN, exp_move);
      check("damageSCEN", damageSCEN, exp_damage);
      check("spawn_req", spawn_req, exp_req);
      if (exp_req != '0) check("spawn_type", spawn_type, exp_type);
      check("enemy_front", enemy_front, exp_front);
      check("wave_num", wave_num, exp_wave);
      check("wave_done", wave_done, exp_wd);
      check("spawn_err", spawn_err, exp_err);
    end
    for (int i = 0; i < NSLOT; i++) begin
      if (ack_due[i] > 0) begin
        ack_due[i]--;
        if (ack_due[i] == 0) slot_alive[i] = 1'b1;
      end
    end
    for (int i = 0; i < NSLOT; i++) begin
      if (spawn_req[i]) begin
        d = resp_delay;
        if (rand_mode) begin
          d = $urandom_range(0, 11);
          if (d >= 10) d = -1;
        end
        if (d == 0) slot_alive[i] = 1'b1;
        else if (d > 0) ack_due[i] = d;
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < NSLOT; i++)
        if (slot_alive[i] && $urandom_range(0, 39) == 0)
          slot_alive[i] = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, NSLOT-1);
        slot_pos[9*k +: 9] = 9'($urandom);
      end
      if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 29) == 0) enable = 1'b1;
    end
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      nstep();
      if (spawn_req != '0) begin
        ok = 1;
        return;
      end
    end
  endtask

  initial begin : stim
    bit ok;
    int t0, tr, f_mv, f_dm, seen, wd_cnt, mv;
    int tv [4];
    tv = '{1, 2, 3, 1};
    n_vec = 0; n_err = 0; cyc_n = 0;
    chk_en = 0; rand_mode = 0; resp_delay = 2;
    enable = 1'b0; slot_alive = '0; slot_pos = '0;
    for (int i = 0; i < NSLOT; i++) ack_due[i] = 0;
    repeat (3) nstep();
    check_zero("reset");
    reset = 1'b1;
    chk_en = 1;

    slot_pos = {9'd300, 9'd17, 9'd200, 9'd5};
    slot_alive = 4'b0111;
    nstep();
    check("front_lit", enemy_front, 200);
    slot_alive = '0;
    nstep();
    check("front_all_dead", enemy_front, 0);
    repeat (20) nstep();

    enable = 1'b1;
    t0 = cyc_n;
    f_mv = -1; f_dm = -1;
    for (int k = 0; k < 17; k++) begin
      nstep();
      if (moveSCEN && f_mv < 0) f_mv = cyc_n - t0;
      if (damageSCEN && f_dm < 0) f_dm = cyc_n - t0;
    end
    check("first_move", f_mv, 16);
    check("first_damage", f_dm, 17);

    tr = t0;
    for (int s = 0; s < 4; s++) begin
      wait_req(300, ok);
      check("spawn_seen", ok, 1);
      if (s == 0) check("first_spawn_delay", cyc_n - t0, 129);
      else check("spawn_spacing", cyc_n - tr, 128);
      tr = cyc_n;
      check("spawn_slot_w0", spawn_req, 1 << s);
      check("spawn_type_w0", spawn_type, tv[s]);
    end

    seen = 0;
    repeat (200) begin
      nstep();
      if (spawn_req != '0) seen = 1;
    end
    check("no_free_slot", seen, 0);
    slot_alive[2] = 1'b0;
    nstep();
    check("freed_slot2", spawn_req, 4);
    check("freed_slot2_type", spawn_type, 2);

    resp_delay = -1;
    repeat (5) nstep();
    slot_alive[0] = 1'b0;
    wait_req(400, ok);
    check("sixth_seen", ok, 1);
    check("sixth_slot", spawn_req, 1);
    check("sixth_type", spawn_type, 3);
    repeat (7) nstep();
    check("err_before_timeout", spawn_err, 0);
    nstep();
    check("err_at_timeout", spawn_err, 1);

    slot_alive = '0;
    for (int i = 0; i < NSLOT; i++) ack_due[i] = 0;
    resp_delay = 2;
    ok = 0;
    for (int k = 0; k < 64; k++) begin
      nstep();
      if (wave_done) begin
        ok = 1;
        break;
      end
    end
    check("wave_done_seen", ok, 1);
    check("wave_num_1", wave_num, 1);
    wd_cnt = 1; mv = 0; ok = 0;
    for (int k = 0; k < 600; k++) begin
      nstep();
      if (wave_done) wd_cnt++;
      if (moveSCEN) mv++;
      if (spawn_req != '0) begin
        ok = 1;
        break;
      end
    end
    check("wave1_spawn_seen", ok, 1);
    check("wave_done_count", wd_cnt, 1);
    check("ticks_to_wave1", mv, 24);
    check("wave1_slot", spawn_req, 1);
    check("wave1_type", spawn_type, 2);

    rand_mode = 1;
    repeat (40000) nstep();
    rand_mode = 0;
    chk_en = 0;
    enable = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_zero("midreset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
